// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Lets two control units take turns on one shared combinational ALU.
//   A granted operation is copied into the ALU operand registers (IDLE).
//   The ALU output is captured one cycle later (EXEC).
//   A one-cycle done pulse goes back to the owner (RESP).
//   When both units are waiting, the one not served last wins.
//
// Ports
//   clock, reset_n      : rising-edge clock, asynchronous active-low reset
//   reqN, opN, aN, bN   : requester N request (held until doneN), opcode, operands
//   doneN               : one-cycle pulse, result belongs to requester N
//   result              : captured ALU result, held between operations
//   alu_op/alu_a/alu_b  : registered inputs to the shared ALU
//   alu_result          : combinational ALU output
//   busy                : high whenever an operation is in flight
//   grant_id            : requester currently or most recently granted
module alu_share_arbiter #(
  parameter int WIDTH = 6,
  parameter int OPW   = 3
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req0,
  input  logic [OPW-1:0]   op0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [OPW-1:0]   op1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] result,
  output logic [OPW-1:0]   alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  output logic             busy,
  output logic             grant_id
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic             grant_vld_s;
  logic             grant_s;
  logic             rr_last_r;
  logic             grant_id_r;
  logic             done0_r;
  logic             done1_r;
  logic             busy_r;
  logic [WIDTH-1:0] result_r;
  logic [OPW-1:0]   alu_op_r;
  logic [WIDTH-1:0] alu_a_r;
  logic [WIDTH-1:0] alu_b_r;

  // Next-state selection and round-robin grant decision
  always_comb begin
    state_s     = state_r;
    grant_vld_s = 1'b0;
    grant_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (req0 && req1) begin
          // Contention: the requester not served last goes first
          grant_vld_s = 1'b1;
          grant_s     = ~rr_last_r;
          state_s     = EXEC;
        end else if (req0) begin
          grant_vld_s = 1'b1;
          grant_s     = 1'b0;
          state_s     = EXEC;
        end else if (req1) begin
          grant_vld_s = 1'b1;
          grant_s     = 1'b1;
          state_s     = EXEC;
        end else begin
          state_s = IDLE;
        end
      end
      EXEC:    state_s = RESP;
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand latch on grant, result capture, done pulses and arbitration history
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      alu_op_r   <= {OPW{1'b0}};
      alu_a_r    <= {WIDTH{1'b0}};
      alu_b_r    <= {WIDTH{1'b0}};
      result_r   <= {WIDTH{1'b0}};
      grant_id_r <= 1'b0;
      rr_last_r  <= 1'b1;
      done0_r    <= 1'b0;
      done1_r    <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      // Operands are frozen from grant until the next grant
      if (grant_vld_s) begin
        alu_op_r   <= grant_s ? op1 : op0;
        alu_a_r    <= grant_s ? a1 : a0;
        alu_b_r    <= grant_s ? b1 : b0;
        grant_id_r <= grant_s;
      end
      // Leaving EXEC: capture the ALU output and raise the owner's done for RESP
      if (state_r == EXEC) begin
        result_r <= alu_result;
        done0_r  <= ~grant_id_r;
        done1_r  <= grant_id_r;
      end else begin
        done0_r <= 1'b0;
        done1_r <= 1'b0;
      end
      if (state_r == RESP) begin
        rr_last_r <= grant_id_r;
      end
      busy_r <= (state_s != IDLE);
    end
  end

  assign done0    = done0_r;
  assign done1    = done1_r;
  assign result   = result_r;
  assign alu_op   = alu_op_r;
  assign alu_a    = alu_a_r;
  assign alu_b    = alu_b_r;
  assign busy     = busy_r;
  assign grant_id = grant_id_r;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter
//   Drives two requesters against alu_share_arbiter with a small behavioural
//   ALU attached, and compares every output each cycle against a
//   transaction-timing model of the arbiter.
module tb_alu_share_arbiter;
  localparam int WIDTH = 6;
  localparam int OPW   = 3;

  logic             clock   = 1'b0;
  logic             reset_n = 1'b0;
  logic             req0 = 1'b0;
  logic             req1 = 1'b0;
  logic [OPW-1:0]   op0  = 3'd0;
  logic [OPW-1:0]   op1  = 3'd0;
  logic [WIDTH-1:0] a0   = 6'd0;
  logic [WIDTH-1:0] b0   = 6'd0;
  logic [WIDTH-1:0] a1   = 6'd0;
  logic [WIDTH-1:0] b1   = 6'd0;
  logic             done0, done1, busy, grant_id;
  logic [WIDTH-1:0] result, alu_a, alu_b, alu_result;
  logic [OPW-1:0]   alu_op;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  // Shared ALU: opcode 0 is the equal comparator, the rest are sibling ops
  function automatic logic [WIDTH-1:0] alu_fn(input logic [OPW-1:0] op,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    case (op)
      3'd0:    alu_fn = (a == b) ? 6'd1 : 6'd0;
      3'd1:    alu_fn = (a != b) ? 6'd1 : 6'd0;
      3'd2:    alu_fn = (a < b) ? 6'd1 : 6'd0;
      3'd3:    alu_fn = a & b;
      3'd4:    alu_fn = a | b;
      3'd5:    alu_fn = a ^ b;
      3'd6:    alu_fn = a;
      default: alu_fn = b;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_op, alu_a, alu_b);

  alu_share_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
    .clock(clock), .reset_n(reset_n),
    .req0(req0), .op0(op0), .a0(a0), .b0(b0),
    .req1(req1), .op1(op1), .a1(a1), .b1(b1),
    .done0(done0), .done1(done1), .result(result),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .busy(busy), .grant_id(grant_id)
  );

  // Model: an op granted at edge g is busy after edges g and g+1, shows done
  // and its result after edge g+1, and the next grant is possible at g+3.
  int               cyc     = 0;
  int               gnt_cyc = -100;
  logic             m_last  = 1'b1;
  logic             m_gid   = 1'b0;
  logic [OPW-1:0]   m_op    = 3'd0;
  logic [WIDTH-1:0] m_a     = 6'd0;
  logic [WIDTH-1:0] m_b     = 6'd0;
  logic [WIDTH-1:0] m_res   = 6'd0;
  logic [WIDTH-1:0] m_pend  = 6'd0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    gnt_cyc = -100;
    m_last  = 1'b1;
    m_gid   = 1'b0;
    m_op    = 3'd0;
    m_a     = 6'd0;
    m_b     = 6'd0;
    m_res   = 6'd0;
    m_pend  = 6'd0;
  endtask

  // One clock: advance the model with the inputs seen at the edge, then check all outputs
  task automatic step();
    @(posedge clock);
    cyc++;
    if (reset_n) begin
      if (cyc == gnt_cyc + 1) m_res = m_pend;
      if (cyc >= gnt_cyc + 3 && (req0 || req1)) begin
        m_gid   = (req0 && req1) ? ~m_last : req1;
        m_last  = m_gid;
        gnt_cyc = cyc;
        m_op    = m_gid ? op1 : op0;
        m_a     = m_gid ? a1 : a0;
        m_b     = m_gid ? b1 : b0;
        m_pend  = alu_fn(m_op, m_a, m_b);
      end
    end
    #1;
    check_eq("done0", done0, (cyc == gnt_cyc + 1) && !m_gid);
    check_eq("done1", done1, (cyc == gnt_cyc + 1) && m_gid);
    check_eq("busy", busy, (cyc == gnt_cyc) || (cyc == gnt_cyc + 1));
    check_eq("result", result, m_res);
    check_eq("grant_id", grant_id, m_gid);
    check_eq("alu_op", alu_op, m_op);
    check_eq("alu_a", alu_a, m_a);
    check_eq("alu_b", alu_b, m_b);
  endtask

  task automatic check_reset_state();
    check_eq("rst_done0", done0, 1'b0);
    check_eq("rst_done1", done1, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_result", result, 6'd0);
    check_eq("rst_grant", grant_id, 1'b0);
    check_eq("rst_alu_op", alu_op, 3'd0);
    check_eq("rst_alu_a", alu_a, 6'd0);
    check_eq("rst_alu_b", alu_b, 6'd0);
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    model_reset();
    #1;
    check_reset_state();
    step();
    step();
    reset_n = 1'b1;
  endtask

  // Step until doneN is seen, bounded; n returns the number of edges taken
  task automatic wait_done(input int id, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!(id == 1 ? done1 : done0) && n < 12);
    check_eq("done_seen", (id == 1) ? done1 : done0, 1'b1);
  endtask

  task automatic new_ops(output logic [OPW-1:0] op, output logic [WIDTH-1:0] a,
                         output logic [WIDTH-1:0] b);
    op = 3'($urandom_range(7, 0));
    a  = 6'($urandom);
    b  = ($urandom_range(1, 0) == 1) ? a : 6'($urandom);
  endtask

  int n;
  int t0;
  int glog[$];

  initial begin
    pulse_reset();

    // Single requester, equal op
    op0 = 3'd0; a0 = 6'd11; b0 = 6'd11; req0 = 1'b1;
    wait_done(0, n);
    check_eq("lat0", n, 2);
    check_eq("eq_result", result, 6'd1);
    check_eq("eq_done1", done1, 1'b0);
    req0 = 1'b0;
    step(); step();

    // Not-equal on requester 1
    op1 = 3'd0; a1 = 6'd12; b1 = 6'd14; req1 = 1'b1;
    wait_done(1, n);
    check_eq("ne_result", result, 6'd0);
    check_eq("ne_grant", grant_id, 1'b1);
    req1 = 1'b0;
    step(); step();

    // Simultaneous requests after reset: requester 0 first, 3 cycles apart
    pulse_reset();
    op0 = 3'd0; a0 = 6'd11; b0 = 6'd11; req0 = 1'b1;
    op1 = 3'd0; a1 = 6'd12; b1 = 6'd14; req1 = 1'b1;
    wait_done(0, n);
    t0 = cyc;
    check_eq("sim_r0", result, 6'd1);
    req0 = 1'b0;
    wait_done(1, n);
    check_eq("sim_gap", cyc - t0, 3);
    check_eq("sim_r1", result, 6'd0);
    req1 = 1'b0;
    step();

    // Round-robin fairness: both keep re-requesting
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 18; i++) begin
      step();
      if (done0) begin glog.push_back(0); new_ops(op0, a0, b0); end
      if (done1) begin glog.push_back(1); new_ops(op1, a1, b1); end
    end
    req0 = 1'b0; req1 = 1'b0;
    step(); step(); step();
    check_eq("rr_count", glog.size(), 6);
    for (int i = 0; i < glog.size(); i++) check_eq("rr_order", glog[i], i % 2);

    // Operand hold after grant
    op0 = 3'd0; a0 = 6'd11; b0 = 6'd11; req0 = 1'b1;
    step();
    a0 = 6'd5;
    wait_done(0, n);
    check_eq("hold_result", result, 6'd1);
    check_eq("hold_alu_a", alu_a, 6'd11);
    req0 = 1'b0;
    step(); step();
    check_eq("hold_alu_a2", alu_a, 6'd11);

    // Reset during EXEC drops the operation; held request completes afterwards
    op0 = 3'd0; a0 = 6'd20; b0 = 6'd20; req0 = 1'b1;
    step();
    reset_n = 1'b0;
    model_reset();
    #1;
    check_eq("mid_busy", busy, 1'b0);
    check_eq("mid_result", result, 6'd0);
    check_eq("mid_done0", done0, 1'b0);
    step(); step();
    reset_n = 1'b1;
    wait_done(0, n);
    check_eq("mid_lat", n, 2);
    check_eq("mid_after", result, 6'd1);
    req0 = 1'b0;
    step();

    // Randomized traffic with re-requests and operand churn
    for (int i = 0; i < 600; i++) begin
      step();
      if (done0) begin
        if ($urandom_range(1, 0) == 0) req0 = 1'b0;
        else new_ops(op0, a0, b0);
      end else if (!req0) begin
        if ($urandom_range(3, 0) == 0) begin req0 = 1'b1; new_ops(op0, a0, b0); end
      end else if ($urandom_range(3, 0) == 0) begin
        new_ops(op0, a0, b0);
      end
      if (done1) begin
        if ($urandom_range(1, 0) == 0) req1 = 1'b0;
        else new_ops(op1, a1, b1);
      end else if (!req1) begin
        if ($urandom_range(3, 0) == 0) begin req1 = 1'b1; new_ops(op1, a1, b1); end
      end else if ($urandom_range(3, 0) == 0) begin
        new_ops(op1, a1, b1);
      end
      if (i == 300) pulse_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
